// File: rtl/banked_dram.sv
// Banked, multi-port data memory with a priority loader port and per-bank
// round-robin arbitration among core ports; low-order address interleaving.
module banked_dram #(
   parameter int NUM_C     = 4,
   parameter int DW        = 16,
   parameter int AW        = 10,
   parameter int NUM_BANKS = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                com_en_i,
   input  logic [AW-1:0]       com_addr_i,
   input  logic [DW-1:0]       com_data_i,
   input  logic [NUM_C-1:0]    req_i,
   input  logic [NUM_C-1:0]    we_i,
   input  logic [NUM_C*AW-1:0] addr_i,
   input  logic [NUM_C*DW-1:0] wdata_i,
   output logic [NUM_C-1:0]    gnt_o,
   output logic [NUM_C-1:0]    rvalid_o,
   output logic [NUM_C*DW-1:0] rdata_o
);

   localparam int BB    = $clog2(NUM_BANKS);
   localparam int BSW   = (BB > 0) ? BB : 1;
   localparam int RW    = AW - BB;
   localparam int RWW   = (RW > 0) ? RW : 1;
   localparam int DEPTH = 1 << RW;
   localparam int CW    = (NUM_C > 1) ? $clog2(NUM_C) : 1;

   logic [DW-1:0]        mem_q [NUM_BANKS][DEPTH];
   logic [CW-1:0]        rr_q  [NUM_BANKS];
   logic [CW-1:0]        rr_d  [NUM_BANKS];
   logic [CW-1:0]        bwin  [NUM_BANKS];
   logic [NUM_BANKS-1:0] lhit;
   logic [NUM_BANKS-1:0] bhit;
   logic [NUM_BANKS-1:0] bgnt;
   logic [BSW-1:0]       cbank [NUM_C];
   logic [RWW-1:0]       crow  [NUM_C];
   logic [BSW-1:0]       lbank;
   logic [RWW-1:0]       lrow;
   logic [NUM_C-1:0]     rvalid_q;
   logic [NUM_C*DW-1:0]  rdata_q;

   // Bank = low address bits, row = remaining high bits (modulo/shift keep NUM_BANKS=1 legal).
   always_comb begin
      lbank = BSW'(32'(com_addr_i) % NUM_BANKS);
      lrow  = RWW'(com_addr_i >> BB);
      for (int i = 0; i < NUM_C; i++) begin
         cbank[i] = BSW'(32'(addr_i[i*AW +: AW]) % NUM_BANKS);
         crow[i]  = RWW'(addr_i[i*AW +: AW] >> BB);
      end
   end

   always_comb begin
      int idx;
      idx   = 0;
      gnt_o = '0;
      lhit  = '0;
      bhit  = '0;
      bgnt  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bwin[b] = '0;
         rr_d[b] = rr_q[b];
         lhit[b] = com_en_i && (lbank == BSW'(b));
         for (int k = 0; k < NUM_C; k++) begin
            idx = (int'(rr_q[b]) + k) % NUM_C;
            if (!bhit[b] && req_i[idx] && (cbank[idx] == BSW'(b))) begin
               bhit[b] = 1'b1;
               bwin[b] = CW'(idx);
            end
         end
         bgnt[b] = bhit[b] && !lhit[b] && !rst_i;
         if (bgnt[b]) begin
            gnt_o[bwin[b]] = 1'b1;
            rr_d[b] = (int'(bwin[b]) == NUM_C - 1) ? '0 : bwin[b] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int b = 0; b < NUM_BANKS; b++) rr_q[b] <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) rr_q[b] <= rr_d[b];
         rvalid_q <= gnt_o & ~we_i;
         for (int i = 0; i < NUM_C; i++) begin
            if (gnt_o[i] && !we_i[i]) rdata_q[i*DW +: DW] <= mem_q[cbank[i]][crow[i]];
         end
      end
   end

   // Storage is deliberately not reset; writes are simply suppressed while rst_i is high.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (lhit[b]) begin
               mem_q[b][lrow] <= com_data_i;
            end else if (bgnt[b] && we_i[bwin[b]]) begin
               mem_q[b][crow[bwin[b]]] <= wdata_i[int'(bwin[b])*DW +: DW];
            end
         end
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_banked_dram.sv
// Directed bench for banked_dram: stimulus pushes expected read returns into
// per-core queues, a negedge monitor pops and compares them as rvalid appears.
module tb_banked_dram;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        com_en = 1'b0;
   logic [9:0]  com_addr = '0;
   logic [15:0] com_data = '0;
   logic [3:0]  req = '0;
   logic [3:0]  we = '0;
   logic [39:0] addr = '0;
   logic [63:0] wdata = '0;
   logic [3:0]  gnt;
   logic [3:0]  rvalid;
   logic [63:0] rdata;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q [4][$];
   int          cyc = 0;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          ord [4];
   logic [15:0] dat [4];

   banked_dram #(.NUM_C(4), .DW(16), .AW(10), .NUM_BANKS(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .com_en_i   (com_en),
      .com_addr_i (com_addr),
      .com_data_i (com_data),
      .req_i      (req),
      .we_i       (we),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .gnt_o      (gnt),
      .rvalid_o   (rvalid),
      .rdata_o    (rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
      total_cnt++;
      if (act !== req_v) $display("FAIL %s: got %0h, required %0h", nm, act, req_v);
      else pass_cnt++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_core(input int i, input logic w, input logic [9:0] a, input logic [15:0] d);
      we[i] = w;
      addr[i*10 +: 10] = a;
      wdata[i*16 +: 16] = d;
   endtask

   task automatic push(input int c, input logic [15:0] d);
      exp_t e;
      e.cyc  = cyc + 1;
      e.data = d;
      exp_q[c].push_back(e);
   endtask

   task automatic load(input logic [9:0] a, input logic [15:0] d);
      com_en = 1'b1;
      com_addr = a;
      com_data = d;
      step();
      com_en = 1'b0;
   endtask

   // Cores in mask read until granted; ord[] is the hand-derived grant order.
   task automatic contend(input logic [3:0] mask, input int n);
      req = mask;
      we  = '0;
      for (int s = 0; s < n; s++) begin
         @(negedge clk);
         chk($sformatf("contend_gnt_step%0d", s), gnt, 64'(4'b0001 << ord[s]));
         push(ord[s], dat[ord[s]]);
         step();
         req[ord[s]] = 1'b0;
      end
      req = '0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         if (rvalid[i] === 1'b1) begin
            if (exp_q[i].size() == 0) begin
               total_cnt++;
               $display("FAIL rvalid_unexpected core%0d: got rvalid=1 rdata=%0h, required rvalid=0", i, rdata[i*16 +: 16]);
            end else begin
               e = exp_q[i].pop_front();
               chk($sformatf("rdata_core%0d", i), rdata[i*16 +: 16], e.data);
               chk($sformatf("rvalid_cycle_core%0d", i), cyc, e.cyc);
            end
         end else if (exp_q[i].size() > 0 && exp_q[i][0].cyc <= cyc) begin
            e = exp_q[i].pop_front();
            chk($sformatf("rvalid_missing_core%0d", i), rvalid[i], 1'b1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1);
   end

   initial begin
      repeat (2) step();
      rst = 1'b0;

      load(10'h020, 16'h1111);
      load(10'h024, 16'h2222);
      load(10'h028, 16'h3333);
      load(10'h02C, 16'h4444);
      load(10'h004, 16'h0404);
      load(10'h008, 16'h0808);
      load(10'h00C, 16'h0C0C);
      load(10'h010, 16'h1010);

      // Core 1 wins bank 0 so its pointer is non-zero before reset.
      set_core(1, 1'b1, 10'h030, 16'h3030);
      req = 4'b0010;
      @(negedge clk);
      chk("pre_reset_gnt", gnt, 4'b0010);
      step();
      req = '0;
      we  = '0;

      // Reset with every port trying to write.
      rst = 1'b1;
      for (int i = 0; i < 4; i++) set_core(i, 1'b1, 10'(10'h020 + 4*i), 16'(16'hBAD0 + i));
      req = 4'b1111;
      com_en = 1'b1;
      com_addr = 10'h020;
      com_data = 16'hDEAD;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("reset_gnt_c%0d", c), gnt, 4'b0000);
         chk($sformatf("reset_rvalid_c%0d", c), rvalid, 4'b0000);
         chk($sformatf("reset_rdata_c%0d", c), rdata, 64'h0);
         step();
      end
      rst = 1'b0;
      com_en = 1'b0;
      req = '0;

      // Memory untouched by the reset-cycle writes; bank-0 pointer back at core 0.
      for (int i = 0; i < 4; i++) set_core(i, 1'b0, 10'(10'h020 + 4*i), 16'h0);
      ord = '{0, 1, 2, 3};
      dat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      contend(4'b1111, 4);

      // Conflict rotation on bank 0.
      for (int i = 0; i < 4; i++) set_core(i, 1'b0, 10'(4*(i+1)), 16'h0);
      ord = '{0, 1, 2, 3};
      dat = '{16'h0404, 16'h0808, 16'h0C0C, 16'h1010};
      contend(4'b1111, 4);

      // Loader write then core read.
      load(10'h005, 16'h1234);
      set_core(2, 1'b0, 10'h005, 16'h0);
      req = 4'b0100;
      @(negedge clk);
      chk("ld_read_gnt", gnt, 4'b0100);
      push(2, 16'h1234);
      step();
      req = '0;

      // Four banks in parallel: write then readback.
      for (int i = 0; i < 4; i++) set_core(i, 1'b1, 10'(i), 16'(16'h00A0 + i));
      req = 4'b1111;
      @(negedge clk);
      chk("par_wr_gnt", gnt, 4'b1111);
      step();
      we = '0;
      @(negedge clk);
      chk("par_rd_gnt", gnt, 4'b1111);
      for (int i = 0; i < 4; i++) push(i, 16'(16'h00A0 + i));
      step();
      req = '0;

      // Loader pre-empts core 1 on bank 0; bank-0 pointer is at 1 here.
      com_en = 1'b1;
      com_addr = 10'h008;
      com_data = 16'h5A5A;
      set_core(1, 1'b1, 10'h00C, 16'h6B6B);
      req = 4'b0010;
      @(negedge clk);
      chk("ldpri_blocked_gnt", gnt, 4'b0000);
      step();
      com_en = 1'b0;
      @(negedge clk);
      chk("ldpri_retry_gnt", gnt, 4'b0010);
      step();
      req = '0;
      we  = '0;

      // Pointer now at 2: core 2 before core 3.
      set_core(2, 1'b0, 10'h008, 16'h0);
      set_core(3, 1'b0, 10'h00C, 16'h0);
      ord[0] = 2;
      ord[1] = 3;
      dat[2] = 16'h5A5A;
      dat[3] = 16'h6B6B;
      contend(4'b1100, 2);

      // Reset lands on the edge that would return core 3's read.
      set_core(3, 1'b0, 10'h003, 16'h0);
      req = 4'b1000;
      @(negedge clk);
      chk("midrst_gnt", gnt, 4'b1000);
      rst = 1'b1;
      step();
      req = '0;
      @(negedge clk);
      chk("midrst_rvalid", rvalid, 4'b0000);
      chk("midrst_rdata", rdata, 64'h0);
      step();
      rst = 1'b0;

      req = 4'b1000;
      @(negedge clk);
      chk("post_rst_gnt", gnt, 4'b1000);
      push(3, 16'h00A3);
      step();
      req = '0;

      repeat (3) step();
      for (int i = 0; i < 4; i++) chk($sformatf("drain_core%0d", i), exp_q[i].size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
